dense_node: RTL and testbench
=============================

Name: dense_node

Overview:
Initiator side of the activation protocol. It buffers N unsigned 8-bit inputs, multiply-accumulates them against internal signed weights, and drives the resulting argument to a sigmoid unit. It takes the activation result, forwards it downstream, then, when training, relays the downstream error to the sigmoid and consumes its feedback to update its own weights. It sits between the previous layer and one activation unit.

Parameters:
N, 4, inputs per dot product (2..64); index counter width is clog2(N).
RATE, 0, extra right shift on weight update (learning-rate divisor 2^RATE).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  training enable, sampled in OUT on out ack
inp_stb  in  1 / inp_dat  in  8 / inp_rdy  out  1  input stream, unsigned Q0.8
arg_stb  out  1 / arg_dat  out  16 / arg_rdy  in  1  argument to activation, signed Q8.8
res_stb  in  1 / res_dat  in  8 / res_rdy  out  1  activation result
out_stb  out  1 / out_dat  out  8 / out_rdy  in  1  result forwarded downstream
bwd_stb  in  1 / bwd_dat  in  16 / bwd_rdy  out  1  error from downstream, signed
err_stb  out  1 / err_dat  out  16 / err_rdy  in  1  error to activation
fbk_stb  in  1 / fbk_dat  in  16 / fbk_rdy  out  1  delta from activation, signed

Behaviour:
- Ack = stb & rdy on every interface. Once asserted, an output stb stays high and its data stays stable until ack. Every rdy is combinational from state only.
- Async reset: state=INP, idx=0, acc=0, all weights w[i]=0, and arg_stb/out_stb/err_stb=0, arg_dat/out_dat/err_dat=0. Strobes drop immediately when rst rises, including mid-transaction. Input buffer contents are don't-care.
- States:
  - INP: inp_rdy=1. On ack: x[idx]<=inp_dat, acc<=acc+w[idx]*x[idx], idx++. Ack at idx=N-1 -> ARG, idx wraps to 0.
  - ARG: arg_stb rises the cycle after entry with arg_dat=sat16(acc>>>8). On ack -> RES.
  - RES: res_rdy=1. On res_stb: out_dat<=res_dat -> OUT.
  - OUT: out_stb rises the cycle after entry. On ack: en ? BWD : INP. acc<=0 on exit to INP.
  - BWD: bwd_rdy=1. On bwd_stb: err_dat<=bwd_dat -> ERR.
  - ERR: err_stb asserted. On ack -> FBK.
  - FBK: fbk_rdy=1. On fbk_stb: latch delta -> UPD.
  - UPD: one weight per cycle, idx 0..N-1: w[idx]<=sat16(w[idx] - ((delta*x[idx])>>>(8+RATE))). After idx=N-1 -> INP, idx=0, acc=0.
- Arithmetic:
  - Products are signed 16 x unsigned 8, giving 24 bits.
  - acc is 24+clog2(N)+1 bits and never wraps.
  - sat16 clamps to 0x7FFF / 0x8000. >>> is arithmetic (floor).
- Latency with no backpressure: last input ack to arg_stb is 1 cycle.
- Inputs arriving outside INP are held off (inp_rdy=0).
- Invalid state: in simulation, print an error and stop. In synthesis it is don't-care.

Optional Feature:
BIAS_EN: when defined, adds a signed 16-bit bias register b (reset 0).
- acc is initialised to b<<8, sign-extended, instead of 0 at every return to INP (and after reset).
- One extra UPD cycle after the weights: b<<=sat16(b - (delta>>>RATE)).
When undefined, acc starts at 0 and there is no bias register or extra cycle.

Test Plan:
- Reset, en=0, inputs 10,20,30,40: arg_dat=0x0000. Return res=0x80: out_dat=0x80, then inp_rdy=1 with no BWD entry.
- en=1, inputs 255,0,0,0, res any, bwd=0x1234 (seen as err_dat=0x1234), fbk=0xFF00: w0=0x00FF, others 0. Next pass en=0, inputs 255,0,0,0: arg_dat=0x00FE.
- en=1, inputs 255 x4, fbk=0x7FFF, twice: all weights saturate to 0x8000. Next pass, inputs 255 x4: arg_dat=0x8000, saturated.
- Hold arg_rdy=0 for 5 cycles, then out_rdy=0 for 3 cycles: stb and data stay stable, inp_rdy=0 throughout, state advances only on ack.
- Assert rst while err_stb=1: err_stb=0 in the same cycle, weights=0, inp_rdy=1 after release. Inputs 255,0,0,0 then give arg_dat=0.
- BIAS_EN, en=1, inputs 0 x4, fbk=0xFF00: b=0x0100. Next pass, inputs 0 x4: arg_dat=0x0100.

Source files
------------

// File: rtl/dense_node.sv
// dense_node: buffers N unsigned inputs, MACs them against signed weights, drives an activation unit
// and, when training, relays the downstream error and applies the returned delta. Optional macro: BIAS_EN.
module dense_node #(
    parameter int N    = 4,
    parameter int RATE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        inp_stb,
    input  logic [7:0]  inp_dat,
    output logic        inp_rdy,
    output logic        arg_stb,
    output logic [15:0] arg_dat,
    input  logic        arg_rdy,
    input  logic        res_stb,
    input  logic [7:0]  res_dat,
    output logic        res_rdy,
    output logic        out_stb,
    output logic [7:0]  out_dat,
    input  logic        out_rdy,
    input  logic        bwd_stb,
    input  logic [15:0] bwd_dat,
    output logic        bwd_rdy,
    output logic        err_stb,
    output logic [15:0] err_dat,
    input  logic        err_rdy,
    input  logic        fbk_stb,
    input  logic [15:0] fbk_dat,
    output logic        fbk_rdy
);
    localparam int IW = $clog2(N);
    localparam int AW = 24 + IW + 1;

    localparam logic [2:0] ST_INP = 3'd0;
    localparam logic [2:0] ST_ARG = 3'd1;
    localparam logic [2:0] ST_RES = 3'd2;
    localparam logic [2:0] ST_OUT = 3'd3;
    localparam logic [2:0] ST_BWD = 3'd4;
    localparam logic [2:0] ST_ERR = 3'd5;
    localparam logic [2:0] ST_FBK = 3'd6;
    localparam logic [2:0] ST_UPD = 3'd7;

    logic [2:0]           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 arg_stb_q, arg_stb_d;
    logic                 out_stb_q, out_stb_d;
    logic                 err_stb_q, err_stb_d;
    logic [15:0]          arg_dat_q, arg_dat_d;
    logic [7:0]           out_dat_q, out_dat_d;
    logic [15:0]          err_dat_q, err_dat_d;
    logic signed [15:0]   delta_q, delta_d;
    logic signed [15:0]   w_q [N];
    logic [7:0]           x_q [N];

    logic                 inp_ack;
    logic                 w_we;
    logic signed [15:0]   w_new;
    logic signed [24:0]   prod_in, prod_up, prod_up_sh;
    logic signed [39:0]   upd_diff, acc_wide;
`ifdef BIAS_EN
    logic signed [15:0]   b_q, b_d;
    logic                 bias_cyc_q, bias_cyc_d;
    logic signed [39:0]   bias_diff;
`endif

    function automatic logic [15:0] sat16(input logic signed [39:0] v);
        if (v > 40'sd32767)
            sat16 = 16'h7FFF;
        else if (v < -40'sd32768)
            sat16 = 16'h8000;
        else
            sat16 = v[15:0];
    endfunction

    // Accumulator start value for a pass: the bias placed at the Q8.8 binary point.
    function automatic logic signed [AW-1:0] acc_of_bias(input logic signed [15:0] b);
        acc_of_bias = $signed({{(AW-24){b[15]}}, b, 8'h00});
    endfunction

    assign inp_ack = inp_stb && (state_q == ST_INP);
    assign prod_in = w_q[idx_q] * $signed({1'b0, inp_dat});
    assign prod_up = delta_q * $signed({1'b0, x_q[idx_q]});
    assign prod_up_sh = prod_up >>> (8 + RATE);
    assign upd_diff = $signed({{24{w_q[idx_q][15]}}, w_q[idx_q]})
                    - $signed({{15{prod_up_sh[24]}}, prod_up_sh});
    assign w_new = sat16(upd_diff);
`ifdef BIAS_EN
    assign bias_diff = $signed({{24{b_q[15]}}, b_q})
                     - ($signed({{24{delta_q[15]}}, delta_q}) >>> RATE);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        arg_stb_d = arg_stb_q;
        out_stb_d = out_stb_q;
        err_stb_d = err_stb_q;
        arg_dat_d = arg_dat_q;
        out_dat_d = out_dat_q;
        err_dat_d = err_dat_q;
        delta_d   = delta_q;
        w_we      = 1'b0;
        acc_wide  = '0;
`ifdef BIAS_EN
        b_d        = b_q;
        bias_cyc_d = bias_cyc_q;
`endif
        // All eight encodings are legal states, so no illegal state can be reached.
        case (state_q)
            ST_INP: if (inp_stb) begin
                acc_d = acc_q + $signed({{(AW-25){prod_in[24]}}, prod_in});
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(N - 1)) begin
                    idx_d     = '0;
                    state_d   = ST_ARG;
                    acc_wide  = $signed({{(40-AW){acc_d[AW-1]}}, acc_d});
                    arg_dat_d = sat16(acc_wide >>> 8);
                    arg_stb_d = 1'b1;
                end
            end
            ST_ARG: if (arg_stb_q && arg_rdy) begin
                arg_stb_d = 1'b0;
                state_d   = ST_RES;
            end
            ST_RES: if (res_stb) begin
                out_dat_d = res_dat;
                out_stb_d = 1'b1;
                state_d   = ST_OUT;
            end
            ST_OUT: if (out_stb_q && out_rdy) begin
                out_stb_d = 1'b0;
                if (en) begin
                    state_d = ST_BWD;
                end else begin
                    state_d = ST_INP;
`ifdef BIAS_EN
                    acc_d = acc_of_bias(b_q);
`else
                    acc_d = '0;
`endif
                end
            end
            ST_BWD: if (bwd_stb) begin
                err_dat_d = bwd_dat;
                err_stb_d = 1'b1;
                state_d   = ST_ERR;
            end
            ST_ERR: if (err_stb_q && err_rdy) begin
                err_stb_d = 1'b0;
                state_d   = ST_FBK;
            end
            ST_FBK: if (fbk_stb) begin
                delta_d = fbk_dat;
                state_d = ST_UPD;
            end
            ST_UPD: begin
`ifdef BIAS_EN
                if (bias_cyc_q) begin
                    b_d        = sat16(bias_diff);
                    bias_cyc_d = 1'b0;
                    acc_d      = acc_of_bias(b_d);
                    state_d    = ST_INP;
                end else begin
                    w_we  = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(N - 1)) begin
                        idx_d      = '0;
                        bias_cyc_d = 1'b1;
                    end
                end
`else
                w_we  = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(N - 1)) begin
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ST_INP;
                end
`endif
            end
            default: state_d = ST_INP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INP;
            idx_q     <= '0;
            acc_q     <= '0;
            arg_stb_q <= 1'b0;
            out_stb_q <= 1'b0;
            err_stb_q <= 1'b0;
            arg_dat_q <= '0;
            out_dat_q <= '0;
            err_dat_q <= '0;
            delta_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            arg_stb_q <= arg_stb_d;
            out_stb_q <= out_stb_d;
            err_stb_q <= err_stb_d;
            arg_dat_q <= arg_dat_d;
            out_dat_q <= out_dat_d;
            err_dat_q <= err_dat_d;
            delta_q   <= delta_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) w_q[i] <= '0;
        end else if (w_we) begin
            w_q[idx_q] <= w_new;
        end
    end

    // The input buffer needs no reset: every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (inp_ack) x_q[idx_q] <= inp_dat;
    end

`ifdef BIAS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q        <= '0;
            bias_cyc_q <= 1'b0;
        end else begin
            b_q        <= b_d;
            bias_cyc_q <= bias_cyc_d;
        end
    end
`endif

    assign inp_rdy = (state_q == ST_INP);
    assign res_rdy = (state_q == ST_RES);
    assign bwd_rdy = (state_q == ST_BWD);
    assign fbk_rdy = (state_q == ST_FBK);
    assign arg_stb = arg_stb_q;
    assign arg_dat = arg_dat_q;
    assign out_stb = out_stb_q;
    assign out_dat = out_dat_q;
    assign err_stb = err_stb_q;
    assign err_dat = err_dat_q;
endmodule

// File: tb/tb_dense_node.sv
// Randomised self-checking bench for dense_node: an integer model of the neuron predicts every
// handshake value, a negedge monitor compares them, and a few literal checks pin the model.
`timescale 1ns/1ps
module tb_dense_node;
    localparam int N    = 4;
    localparam int RATE = 0;
    localparam int TMO  = 200;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic        inp_stb = 1'b0, arg_rdy = 1'b0, res_stb = 1'b0, out_rdy = 1'b0;
    logic        bwd_stb = 1'b0, err_rdy = 1'b0, fbk_stb = 1'b0;
    logic [7:0]  inp_dat = '0, res_dat = '0;
    logic [15:0] bwd_dat = '0, fbk_dat = '0;
    logic        inp_rdy, arg_stb, res_rdy, out_stb, bwd_rdy, err_stb, fbk_rdy;
    logic [15:0] arg_dat, err_dat;
    logic [7:0]  out_dat;

    dense_node #(.N(N), .RATE(RATE)) dut (
        .clk(clk), .rst(rst), .en(en),
        .inp_stb(inp_stb), .inp_dat(inp_dat), .inp_rdy(inp_rdy),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
        .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
        .out_stb(out_stb), .out_dat(out_dat), .out_rdy(out_rdy),
        .bwd_stb(bwd_stb), .bwd_dat(bwd_dat), .bwd_rdy(bwd_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
        .fbk_stb(fbk_stb), .fbk_dat(fbk_dat), .fbk_rdy(fbk_rdy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [15:0] exp_arg[$], exp_err[$];
    logic [7:0]  exp_out[$];
    int mw[N];
    int mb = 0;
    int cur_x[N];
    logic [15:0] last_arg, last_err, tmp;
    logic [7:0]  last_out;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int sat16i(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Monitor: each handshake checked against the model queues; held strobes must stay stable.
    logic pa_hold = 1'b0, po_hold = 1'b0, pe_hold = 1'b0;
    logic [15:0] pa_dat, pe_dat;
    logic [7:0]  po_dat;
    always @(negedge clk) begin
        if (rst) begin
            pa_hold = 1'b0; po_hold = 1'b0; pe_hold = 1'b0;
        end else begin
            if (pa_hold) begin chk("arg_stb_held", arg_stb, 1); chk("arg_dat_held", arg_dat, pa_dat); end
            if (po_hold) begin chk("out_stb_held", out_stb, 1); chk("out_dat_held", out_dat, po_dat); end
            if (pe_hold) begin chk("err_stb_held", err_stb, 1); chk("err_dat_held", err_dat, pe_dat); end
            if (arg_stb && arg_rdy) begin
                if (exp_arg.size() == 0) chk("arg_unexpected", 1, 0);
                else chk("arg_dat", arg_dat, exp_arg.pop_front());
            end
            if (out_stb && out_rdy) begin
                if (exp_out.size() == 0) chk("out_unexpected", 1, 0);
                else chk("out_dat", out_dat, exp_out.pop_front());
            end
            if (err_stb && err_rdy) begin
                if (exp_err.size() == 0) chk("err_unexpected", 1, 0);
                else chk("err_dat", err_dat, exp_err.pop_front());
            end
            if (arg_stb || out_stb || err_stb) chk("inp_rdy_busy", inp_rdy, 0);
            pa_hold = arg_stb && !arg_rdy; pa_dat = arg_dat;
            po_hold = out_stb && !out_rdy; po_dat = out_dat;
            pe_hold = err_stb && !err_rdy; pe_dat = err_dat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_of(input int ch);
        case (ch)
            0: return inp_rdy;
            1: return res_rdy;
            2: return bwd_rdy;
            default: return fbk_rdy;
        endcase
    endfunction

    function automatic logic stb_of(input int ch);
        case (ch)
            0: return arg_stb;
            1: return out_stb;
            default: return err_stb;
        endcase
    endfunction

    task automatic push_in(input int ch, input logic [15:0] d);
        int t = 0;
        case (ch)
            0: begin inp_stb = 1'b1; inp_dat = d[7:0]; end
            1: begin res_stb = 1'b1; res_dat = d[7:0]; end
            2: begin bwd_stb = 1'b1; bwd_dat = d; end
            default: begin fbk_stb = 1'b1; fbk_dat = d; end
        endcase
        while (!rdy_of(ch) && t < TMO) begin tick(); t++; end
        if (t >= TMO) chk("push_timeout", ch, -1);
        tick();
        inp_stb = 1'b0; res_stb = 1'b0; bwd_stb = 1'b0; fbk_stb = 1'b0;
    endtask

    task automatic take(input int ch, input int hold, output logic [15:0] v);
        int t = 0;
        v = '0;
        while (!stb_of(ch) && t < TMO) begin tick(); t++; end
        if (t >= TMO) begin chk("take_timeout", ch, -1); return; end
        repeat (hold) tick();
        case (ch)
            0: begin arg_rdy = 1'b1; v = arg_dat; end
            1: begin out_rdy = 1'b1; v = {8'h00, out_dat}; end
            default: begin err_rdy = 1'b1; v = err_dat; end
        endcase
        tick();
        arg_rdy = 1'b0; out_rdy = 1'b0; err_rdy = 1'b0;
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        cur_x[0] = a; cur_x[1] = b; cur_x[2] = c; cur_x[3] = d;
    endtask

    task automatic expect_pass(input logic en_v, input logic [7:0] res, input logic [15:0] bwd);
        longint s = longint'(mb) * 256;
        for (int i = 0; i < N; i++) s += longint'(mw[i]) * cur_x[i];
        exp_arg.push_back(16'(sat16i(s >>> 8)));
        exp_out.push_back(res);
        if (en_v) exp_err.push_back(bwd);
    endtask

    task automatic do_pass(input logic en_v, input logic [7:0] res, input logic [15:0] bwd,
                           input logic [15:0] fbk, input int ah, input int oh);
        expect_pass(en_v, res, bwd);
        en = en_v;
        for (int i = 0; i < N; i++) push_in(0, 16'(cur_x[i]));
        take(0, ah, last_arg);
        push_in(1, {8'h00, res});
        take(1, oh, tmp);
        last_out = tmp[7:0];
        if (en_v) begin
            push_in(2, bwd);
            take(2, 0, last_err);
            push_in(3, fbk);
            for (int i = 0; i < N; i++)
                mw[i] = sat16i(longint'(mw[i]) - ((longint'($signed(fbk)) * cur_x[i]) >>> (8 + RATE)));
`ifdef BIAS_EN
            mb = sat16i(longint'(mb) - longint'(int'($signed(fbk)) >>> RATE));
`endif
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mw[i] = 0;
        mb = 0;
        exp_arg.delete(); exp_out.delete(); exp_err.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inp_rdy", inp_rdy, 1);
        chk("rst_arg_stb", arg_stb, 0);
        chk("rst_arg_dat", arg_dat, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_err_dat", err_dat, 0);
        rst = 1'b0;
        tick();

        // Untrained pass: zero weights, no backward phase.
        set_x(10, 20, 30, 40);
        do_pass(1'b0, 8'h80, 16'h0, 16'h0, 0, 0);
        chk("t1_arg", last_arg, 16'h0000);
        chk("t1_out", last_out, 8'h80);
        chk("t1_inp_rdy_after", inp_rdy, 1);
        chk("t1_bwd_rdy_after", bwd_rdy, 0);

        // One training step gives w0 = 0x00FF.
        set_x(255, 0, 0, 0);
        do_pass(1'b1, 8'h3C, 16'h1234, 16'hFF00, 0, 0);
        chk("t2_err", last_err, 16'h1234);
        do_pass(1'b0, 8'h01, 16'h0, 16'h0, 0, 0);
        chk("t2_arg", last_arg, 16'h00FE);

        // Drive all weights into negative saturation, with backpressure on arg and out.
        set_x(255, 255, 255, 255);
        do_pass(1'b1, 8'h00, 16'h0001, 16'h7FFF, 0, 0);
        do_pass(1'b1, 8'h00, 16'h0002, 16'h7FFF, 0, 0);
        do_pass(1'b0, 8'h5A, 16'h0, 16'h0, 5, 3);
        chk("t3_arg_sat", last_arg, 16'h8000);
        chk("t3_model_w3", mw[3], -32768);

        // Asynchronous reset while err_stb is waiting for its ack.
        set_x(1, 2, 3, 4);
        expect_pass(1'b1, 8'h11, 16'h2222);
        en = 1'b1;
        for (int i = 0; i < N; i++) push_in(0, 16'(cur_x[i]));
        take(0, 0, last_arg);
        push_in(1, 16'h0011);
        take(1, 0, tmp);
        push_in(2, 16'h2222);
        chk("t5_err_stb_pre", err_stb, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_err_stb_rst", err_stb, 0);
        chk("t5_err_dat_rst", err_dat, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("t5_inp_rdy", inp_rdy, 1);
        set_x(255, 0, 0, 0);
        do_pass(1'b0, 8'h22, 16'h0, 16'h0, 0, 0);
        chk("t5_arg_zero", last_arg, 16'h0000);

`ifdef BIAS_EN
        set_x(0, 0, 0, 0);
        do_pass(1'b1, 8'h00, 16'h0003, 16'hFF00, 0, 0);
        do_pass(1'b0, 8'h00, 16'h0, 16'h0, 0, 0);
        chk("t6_bias_arg", last_arg, 16'h0100);
`endif

        // Randomised passes checked by the model through the monitor.
        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < N; i++)
                cur_x[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            do_pass(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (4) tick();
        chk("arg_queue_drained", exp_arg.size(), 0);
        chk("out_queue_drained", exp_out.size(), 0);
        chk("err_queue_drained", exp_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
